// File: rtl/input_interface_if.sv
// Host/engine-side signal bundle for the AES byte-serial input front end.
interface input_interface_if #(
  parameter int unsigned BYTES = 16
);
  localparam int unsigned BLK_W = 8 * BYTES;

  logic [7:0]       data_in;
  logic             data_valid;
  logic             key_sel;
  logic             engine_busy;
  logic [BLK_W-1:0] plaintext;
  logic [BLK_W-1:0] key;
  logic             start;
  logic             input_ready;
  logic             key_loaded;
  logic             err;

  // Host / engine side: drives bytes and busy, observes block outputs
  modport master (
    output data_in, data_valid, key_sel, engine_busy,
    input  plaintext, key, start, input_ready, key_loaded, err
  );

  // Front-end block side
  modport slave (
    input  data_in, data_valid, key_sel, engine_busy,
    output plaintext, key, start, input_ready, key_loaded, err
  );
endinterface

// File: rtl/input_interface.sv
// Byte-serial AES input front end: assembles 16 host bytes MSB-first into a
// key or plaintext block and hands plaintext to the round transformer with a
// one-cycle start pulse once the engine is idle. Staging doubles as the second
// buffer, so a new block can load while the engine works on the previous one.
// Only BYTES = 16 is supported.
module input_interface #(
  parameter int unsigned BYTES = 16
) (
  input logic               clk,
  input logic               rst_,
  input_interface_if.slave  bus
);

  localparam int unsigned BLK_W = 8 * BYTES;
  localparam int unsigned CNT_W = $clog2(BYTES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    FULL_PT  = 2'd2,
    FULL_KEY = 2'd3
  } state_t;

  state_t           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  logic [BLK_W-1:0] staging_q,    staging_d;
  logic             blk_is_key_q, blk_is_key_d;
  logic [BLK_W-1:0] plaintext_q,  plaintext_d;
  logic [BLK_W-1:0] key_q,        key_d;
  logic             start_q,      start_d;
  logic             key_loaded_q, key_loaded_d;
  logic             err_q,        err_d;

  logic             input_ready_c;
  logic             accept_c;

  // State register and datapath flops; reset discards any partial/pending block
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      staging_q    <= '0;
      blk_is_key_q <= 1'b0;
      plaintext_q  <= '0;
      key_q        <= '0;
      start_q      <= 1'b0;
      key_loaded_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      staging_q    <= staging_d;
      blk_is_key_q <= blk_is_key_d;
      plaintext_q  <= plaintext_d;
      key_q        <= key_d;
      start_q      <= start_d;
      key_loaded_q <= key_loaded_d;
      err_q        <= err_d;
    end
  end

  // Next-state, byte assembly and hand-off decisions
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    staging_d     = staging_q;
    blk_is_key_d  = blk_is_key_q;
    plaintext_d   = plaintext_q;
    key_d         = key_q;
    start_d       = 1'b0;
    key_loaded_d  = key_loaded_q;
    err_d         = err_q;

    input_ready_c = (state_q == IDLE) || (state_q == LOAD);
    accept_c      = bus.data_valid && input_ready_c;

    // A byte offered while a full block waits for hand-off is lost
    if (bus.data_valid && !input_ready_c) begin
      err_d = 1'b1;
    end

    if (accept_c) begin
      staging_d = {staging_q[BLK_W-9:0], bus.data_in};
    end

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          blk_is_key_d = bus.key_sel;
          cnt_d        = CNT_W'(1);
          state_d      = LOAD;
        end
      end
      LOAD: begin
        if (accept_c) begin
          if (cnt_q == CNT_W'(BYTES - 1)) begin
            cnt_d = '0;
            if (blk_is_key_q) begin
              state_d = FULL_KEY;
            end else if (key_loaded_q) begin
              state_d = FULL_PT;
            end else begin
              // Plaintext with no key to encrypt it under is dropped
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FULL_PT: begin
        if (!bus.engine_busy) begin
          plaintext_d = staging_q;
          start_d     = 1'b1;
          state_d     = IDLE;
        end
      end
      FULL_KEY: begin
        if (!bus.engine_busy) begin
          key_d        = staging_q;
          key_loaded_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output mapping
  assign bus.plaintext   = plaintext_q;
  assign bus.key         = key_q;
  assign bus.start       = start_q;
  assign bus.input_ready = input_ready_c;
  assign bus.key_loaded  = key_loaded_q;
  assign bus.err         = err_q;

endmodule
